// File: rtl/pic_timer_pkg.sv
// Shared definitions for the midrange TMR0/WDT timer slice: OPTION bit
// positions, the TMR0 write-inhibit state encoding and the prescaler mask helper.
package pic_timer_pkg;

  // OPTION register bit positions
  localparam int unsigned T0CS_BIT = 5;
  localparam int unsigned T0SE_BIT = 4;
  localparam int unsigned PSA_BIT  = 3;
  localparam int unsigned PS_MSB   = 2;
  localparam int unsigned PS_LSB   = 0;
  localparam int unsigned PS_W     = PS_MSB - PS_LSB + 1;

  // Increment-inhibit sequence entered on every TMR0 write
  typedef enum logic [1:0] {
    INH_IDLE = 2'b00,
    INH_1    = 2'b01,
    INH_2    = 2'b10
  } inh_state_e;

  // Decoded OPTION fields used by the prescaler controller
  typedef struct packed {
    logic            t0cs;
    logic            t0se;
    logic            psa;
    logic [PS_W-1:0] ps;
  } option_t;

  // Low-bit mask whose all-ones condition marks a prescaler output tick:
  // PS selects division 2^(PS+1), so the mask is (2 << PS) - 1.
  function automatic logic [31:0] ps_mask(input logic [PS_W-1:0] ps);
    return (32'd2 << ps) - 32'd1;
  endfunction

endpackage

// File: rtl/t0cki_edge_detect.sv
// T0CKI edge detector: optional 2-flop synchroniser (TMR0_T0CKI_SYNC_EN),
// T0SE polarity select, and a pending latch that holds a detected edge until
// the next q_tick consumes it.
module t0cki_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic t0cki_in,
  input  logic t0se,
  input  logic q_tick,
  output logic edge_evt
);

  logic pin_s;
  logic hist_q, hist_d;
  logic pend_q, pend_d;
  logic edge_seen;

`ifdef TMR0_T0CKI_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Two-stage shift toward the edge detector
  always_comb begin
    sync_d = {sync_q[0], t0cki_in};
  end

  // Synchroniser flops
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pin_s = sync_q[1];
`else
  assign pin_s = t0cki_in;
`endif

  // Edge of the selected polarity; an edge seen in a q_tick clk stays pending
  // for the following q_tick so it is never lost.
  always_comb begin
    hist_d    = pin_s;
    edge_seen = t0se ? (hist_q & ~pin_s) : (~hist_q & pin_s);
    pend_d    = (pend_q & ~q_tick) | edge_seen;
    edge_evt  = pend_q & q_tick;
  end

  // History and pending flops
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/tmr0_prescaler_ctrl.sv
// TMR0 increment sequencer and TMR0/WDT prescaler arbiter for the midrange core.
// Build option: define TMR0_T0CKI_SYNC_EN to add a 2-flop T0CKI synchroniser.
// INHIBIT_CYCLES is expected to be at least 2.
module tmr0_prescaler_ctrl
  import pic_timer_pkg::*;
#(
  parameter int unsigned PRESCALER_W    = 8,
  parameter int unsigned INHIBIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   q_tick,
  input  logic [7:0]             option_in,
  input  logic                   t0cki_in,
  input  logic                   tmr0_write_en,
  input  logic                   clrwdt_en,
  input  logic                   wdt_tick,
  output logic                   tmr0_inc_en,
  output logic                   wdt_inc_en,
  output logic [PRESCALER_W-1:0] prescaler_out
);

  localparam int unsigned INH_CNT_W =
    (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;

  option_t                opt;
  logic [1:0]             unused_opt_bits;
  logic                   ext_evt;
  logic                   src_evt;
  logic                   pre_evt;
  logic [PRESCALER_W-1:0] pre_mask;
  logic                   pre_clr;
  logic                   pre_tick;
  logic                   tmr0_tick;

  logic [PRESCALER_W-1:0] pre_q, pre_d;
  logic                   psa_q, psa_d;
  inh_state_e             inh_q, inh_d;
  logic [INH_CNT_W-1:0]   inh_cnt_q, inh_cnt_d;

  // Decode the OPTION fields this block consumes
  always_comb begin
    opt.t0cs        = option_in[T0CS_BIT];
    opt.t0se        = option_in[T0SE_BIT];
    opt.psa         = option_in[PSA_BIT];
    opt.ps          = option_in[PS_MSB:PS_LSB];
    unused_opt_bits = option_in[7:6];
  end

  t0cki_edge_detect u_edge (
    .clk      (clk),
    .rst      (rst),
    .t0cki_in (t0cki_in),
    .t0se     (opt.t0se),
    .q_tick   (q_tick),
    .edge_evt (ext_evt)
  );

  // Source selection, prescaler ownership and tick detection; a clear in the
  // same clk suppresses the tick as well as the increment.
  always_comb begin
    src_evt  = opt.t0cs ? ext_evt : q_tick;
    pre_evt  = opt.psa ? wdt_tick : src_evt;
    pre_mask = PRESCALER_W'(ps_mask(opt.ps));
    psa_d    = opt.psa;
    pre_clr  = (psa_q != opt.psa)
             | (tmr0_write_en & ~opt.psa)
             | (clrwdt_en & opt.psa);
    pre_tick = pre_evt & ((pre_q & pre_mask) == pre_mask) & ~pre_clr;
  end

  // Prescaler count: clear beats increment, PS changes act on the live count
  always_comb begin
    pre_d = pre_q;
    if (pre_clr) begin
      pre_d = '0;
    end else if (pre_evt) begin
      pre_d = pre_q + PRESCALER_W'(1);
    end
  end

  // Inhibit sequencer: a write always restarts at INH_1, q_ticks walk it home.
  // INH_2 is held for INHIBIT_CYCLES-1 q_ticks using a small counter.
  always_comb begin
    inh_d     = inh_q;
    inh_cnt_d = inh_cnt_q;
    if (tmr0_write_en) begin
      inh_d     = INH_1;
      inh_cnt_d = '0;
    end else if (q_tick) begin
      case (inh_q)
        INH_1: begin
          inh_d     = INH_2;
          inh_cnt_d = '0;
        end
        INH_2: begin
          if (inh_cnt_q == INH_CNT_W'(INHIBIT_CYCLES - 2)) begin
            inh_d     = INH_IDLE;
            inh_cnt_d = '0;
          end else begin
            inh_cnt_d = inh_cnt_q + INH_CNT_W'(1);
          end
        end
        default: begin
          inh_d     = INH_IDLE;
          inh_cnt_d = '0;
        end
      endcase
    end
  end

  // Output pulses, forced low while reset is held
  always_comb begin
    tmr0_tick     = opt.psa ? src_evt : pre_tick;
    tmr0_inc_en   = ~rst & tmr0_tick & (inh_q == INH_IDLE) & ~tmr0_write_en;
    wdt_inc_en    = ~rst & (opt.psa ? pre_tick : wdt_tick);
    prescaler_out = pre_q;
  end

  // State registers; psa_q reloads from OPTION so reset never reads as a PSA change
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q     <= '0;
      psa_q     <= option_in[PSA_BIT];
      inh_q     <= INH_IDLE;
      inh_cnt_q <= '0;
    end else begin
      pre_q     <= pre_d;
      psa_q     <= psa_d;
      inh_q     <= inh_d;
      inh_cnt_q <= inh_cnt_d;
    end
  end

endmodule
